game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 117 +++++++++++
 tb/tb_game_state_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game-flow controller for a flappy-bird style game: IDLE/PLAY/OVER/PAUSE sequencing,
// pipe-crossing score, best-score tracking and the post-game-over restart lockout.
module game_state_ctrl #(
  parameter int BIRD_X    = 160,
  parameter int OVER_HOLD = 500
) (
  input  logic       clk_2ms,
  input  logic       rst_n,
  input  logic       btn_flap,
  input  logic       btn_pause,
  input  logic       collision,
  input  logic [9:0] pip_X,
  output logic [1:0] state,
  output logic       flap,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic       new_best
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam int HW = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(OVER_HOLD - 1);
  localparam logic [9:0]    BIRD_COL  = 10'(BIRD_X);

  state_t        state_q, state_d;
  logic          flap_q, flap_d;
  logic          new_best_q, new_best_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    best_q, best_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          flap_prev, pause_prev;
  logic [9:0]    pip_prev;

  logic flap_edge, pause_edge, crossing;

  assign flap_edge  = btn_flap & ~flap_prev;
  assign pause_edge = btn_pause & ~pause_prev;
  // A reload jumps pip_X upward, so only a downward pass through BIRD_X counts.
  assign crossing   = (pip_prev > BIRD_COL) && (pip_X <= BIRD_COL);

  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      flap_q     <= 1'b0;
      new_best_q <= 1'b0;
      score_q    <= 8'd0;
      best_q     <= 8'd0;
      hold_q     <= '0;
      flap_prev  <= 1'b0;
      pause_prev <= 1'b0;
      pip_prev   <= 10'd0;
    end else begin
      state_q    <= state_d;
      flap_q     <= flap_d;
      new_best_q <= new_best_d;
      score_q    <= score_d;
      best_q     <= best_d;
      hold_q     <= hold_d;
      flap_prev  <= btn_flap;
      pause_prev <= btn_pause;
      pip_prev   <= pip_X;
    end
  end

  always_comb begin
    state_d    = state_q;
    flap_d     = 1'b0;
    new_best_d = 1'b0;
    score_d    = score_q;
    best_d     = best_q;
    hold_d     = hold_q;
    case (state_q)
      S_IDLE: begin
        if (flap_edge) begin
          state_d = S_PLAY;
          score_d = 8'd0;
          flap_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (collision) begin
          state_d = S_OVER;
          hold_d  = HOLD_LOAD;
          if (score_q > best_q) begin
            best_d     = score_q;
            new_best_d = 1'b1;
          end
        end else begin
          if (crossing && (score_q != 8'hFF)) score_d = score_q + 8'd1;
          if (pause_edge)     state_d = S_PAUSE;
          else if (flap_edge) flap_d  = 1'b1;
        end
      end
      S_PAUSE: begin
        if (pause_edge) state_d = S_PLAY;
      end
      S_OVER: begin
        if (hold_q != '0)   hold_d  = hold_q - 1'b1;
        else if (flap_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state    = state_q;
  assign flap     = flap_q;
  assign new_best = new_best_q;
  assign score    = score_q;
  assign best     = best_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed game scenarios plus random play, each cycle's
// expected outputs come from a rule-level model and are checked by a separate monitor.
module tb_game_state_ctrl;

  localparam int BIRD_X    = 160;
  localparam int OVER_HOLD = 500;
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2, M_PAUSE = 3;

  logic       clk_2ms = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_flap = 1'b0;
  logic       btn_pause = 1'b0;
  logic       collision = 1'b0;
  logic [9:0] pip_X = 10'd0;
  logic [1:0] state;
  logic       flap;
  logic [7:0] score;
  logic [7:0] best;
  logic       new_best;

  int tests = 0;
  int fails = 0;
  logic [19:0] exp_q[$];

  // model of the game rules
  int m_mode = M_IDLE, m_score = 0, m_best = 0, m_over_cycles = 0, m_prev_pip = 0;
  bit m_prev_flap = 0, m_prev_pause = 0;

  game_state_ctrl #(.BIRD_X(BIRD_X), .OVER_HOLD(OVER_HOLD)) dut (
    .clk_2ms(clk_2ms), .rst_n(rst_n), .btn_flap(btn_flap), .btn_pause(btn_pause),
    .collision(collision), .pip_X(pip_X), .state(state), .flap(flap),
    .score(score), .best(best), .new_best(new_best)
  );

  always #5 clk_2ms = ~clk_2ms;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // Driver: inputs change on the falling edge; the model predicts the next rising edge.
  task automatic step(input bit r, input bit f, input bit p, input bit c, input int x);
    bit fe, pe, crossed, fl, nb;
    @(negedge clk_2ms);
    rst_n = r; btn_flap = f; btn_pause = p; collision = c; pip_X = 10'(x);
    fl = 0; nb = 0;
    if (!r) begin
      m_mode = M_IDLE; m_score = 0; m_best = 0; m_over_cycles = 0;
      m_prev_pip = 0; m_prev_flap = 0; m_prev_pause = 0;
    end else begin
      fe = f && !m_prev_flap;
      pe = p && !m_prev_pause;
      crossed = (m_prev_pip > BIRD_X) && (x <= BIRD_X);
      case (m_mode)
        M_IDLE: if (fe) begin m_mode = M_PLAY; m_score = 0; fl = 1; end
        M_PLAY: begin
          if (c) begin
            m_mode = M_OVER;
            m_over_cycles = 0;
            if (m_score > m_best) begin m_best = m_score; nb = 1; end
          end else begin
            if (crossed && m_score < 255) m_score++;
            if (pe) m_mode = M_PAUSE;
            else if (fe) fl = 1;
          end
        end
        M_PAUSE: if (pe) m_mode = M_PLAY;
        default: begin
          // restart allowed once OVER_HOLD clock edges have elapsed since entry
          m_over_cycles++;
          if (fe && m_over_cycles >= OVER_HOLD) m_mode = M_IDLE;
        end
      endcase
      m_prev_flap = f; m_prev_pause = p; m_prev_pip = x;
    end
    exp_q.push_back({2'(m_mode), fl, 8'(m_score), 8'(m_best), nb});
  endtask

  task automatic cross_bird(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, BIRD_X + 1);
      step(1, 0, 0, 0, BIRD_X);
    end
  endtask

  // Monitor: every rising edge presents a fresh output word.
  always @(posedge clk_2ms) begin
    logic [19:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, flap, score, best, new_best};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t: got state=%0d flap=%0d score=%0d best=%0d new_best=%0d, expected state=%0d flap=%0d score=%0d best=%0d new_best=%0d",
                 $time, a[19:18], a[17], a[16:9], a[8:1], a[0], e[19:18], e[17], e[16:9], e[8:1], e[0]);
      end
    end
  end

  task automatic check_all_zero(input string name);
    tests++;
    if ({state, flap, score, best, new_best} !== 20'd0) begin
      fails++;
      $display("FAIL %s: got state=%0d flap=%0d score=%0d best=%0d new_best=%0d, expected all 0",
               name, state, flap, score, best, new_best);
    end
  endtask

  initial begin
    int px;
    #1;
    check_all_zero("reset_initial");
    repeat (3) step(0, 0, 0, 0, 0);

    // start: flap held for 10 cycles gives one edge and one pulse
    repeat (10) step(1, 1, 0, 0, 300);
    step(1, 0, 0, 0, 300);

    // exactly one score on 161->160, then a reload does not score
    step(1, 0, 0, 0, 162);
    step(1, 0, 0, 0, 161);
    step(1, 0, 0, 0, 160);
    step(1, 0, 0, 0, 159);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 740);

    // up to 7, then collision coincident with crossing and flap edge
    cross_bird(6);
    step(1, 0, 0, 0, BIRD_X + 1);
    step(1, 1, 0, 1, BIRD_X);
    // OVER lockout: early flap ignored, pause/collision ignored, flap at edge 500 restarts
    for (int k = 1; k <= OVER_HOLD; k++)
      step(1, (k == 100) || (k == OVER_HOLD), (k == 200), (k == 300), 500);
    step(1, 0, 0, 0, 500);

    // second game ends at 5: best stays 7
    step(1, 1, 0, 0, 500);
    step(1, 0, 0, 0, 500);
    cross_bird(5);
    step(1, 0, 0, 1, 500);
    for (int k = 1; k <= OVER_HOLD; k++) step(1, (k == OVER_HOLD), 0, 0, 500);
    step(1, 0, 0, 0, 500);
    step(1, 1, 0, 0, 500);
    step(1, 0, 0, 0, 500);

    // pause freezes play; no false crossing on resume
    step(1, 0, 0, 0, 200);
    step(1, 0, 1, 0, 200);
    step(1, 0, 0, 0, 200);
    step(1, 1, 0, 1, 100);
    step(1, 0, 0, 0, 100);
    step(1, 0, 1, 0, 100);
    step(1, 0, 0, 0, 100);
    step(1, 1, 0, 0, 90);
    step(1, 0, 0, 0, 80);

    // saturation at 255
    cross_bird(258);

    // asynchronous reset mid-PLAY
    @(posedge clk_2ms);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_play");
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // button already held when reset releases: start on the first clock
    step(1, 1, 0, 0, 400);
    step(1, 0, 0, 0, 400);

    // random play
    px = 600;
    for (int i = 0; i < 2500; i++) begin
      px = px - int'($urandom_range(0, 4));
      if (px < 20) px = int'($urandom_range(300, 740));
      step(1, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 79) == 0, px);
    end

    @(posedge clk_2ms);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
